// File: rtl/sha512_block_assembler.sv
// sha512_block_assembler
//   Collects two 512-bit cache-line halves (lower first) into one 1024-bit
//   SHA-512 block, hands it to a SHA-512 core with an init/next pulse, and
//   reports the final digest once the configured number of blocks has been
//   hashed.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   block/block_valid   incoming half; accepted only the cycle after ready
//   ready               registered request for one half
//   msg_blocks          1024-bit blocks per message (0 behaves as 1)
//   core_block          assembled block, stable while the core works on it
//   core_init/core_next one-cycle start pulses to the core
//   core_ready          core can take a start pulse
//   core_digest(_valid) core hash state and its completion pulse
//   digest/digest_valid final message digest and its one-cycle pulse
//   overrun             sticky: a half arrived that was not requested
module sha512_block_assembler #(
    parameter int BYTE_SWAP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [511:0]  block,
    input  logic          block_valid,
    output logic          ready,
    input  logic [31:0]   msg_blocks,
    output logic [1023:0] core_block,
    output logic          core_init,
    output logic          core_next,
    input  logic          core_ready,
    input  logic [511:0]  core_digest,
    input  logic          core_digest_valid,
    output logic [511:0]  digest,
    output logic          digest_valid,
    output logic          overrun
);

    typedef enum logic [1:0] {S_LO, S_HI, S_ISSUE, S_BUSY} state_t;

    state_t       state, state_nx;
    logic         ready_d;      // ready was high last cycle: a half may land now
    logic [31:0]  blk_cnt;
    logic [31:0]  eff_blocks;
    logic         last_blk;
    logic         take_lo, take_hi;
    logic         overrun_set;
    logic [511:0] lo_mapped, hi_mapped;

    function automatic logic [63:0] order64(input logic [63:0] w);
        if (BYTE_SWAP != 0)
            return {w[7:0], w[15:8], w[23:16], w[31:24],
                    w[39:32], w[47:40], w[55:48], w[63:56]};
        else
            return w;
    endfunction

    // Host word k of a half becomes SHA word k of that half; SHA word 0
    // sits at the most significant end.
    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_map
            assign lo_mapped[511-64*k -: 64] = order64(block[64*k +: 64]);
            assign hi_mapped[511-64*k -: 64] = order64(block[64*k +: 64]);
        end
    endgenerate

    assign eff_blocks = (msg_blocks == 32'd0) ? 32'd1 : msg_blocks;
    // 33-bit compare so blk_cnt = 2^32-1 cannot wrap into a false "not last".
    assign last_blk   = ({1'b0, blk_cnt} + 33'd1) >= {1'b0, eff_blocks};

    always_comb begin
        state_nx  = state;
        core_init = 1'b0;
        core_next = 1'b0;
        take_lo   = 1'b0;
        take_hi   = 1'b0;
        case (state)
            S_LO: if (block_valid && ready_d) begin
                take_lo  = 1'b1;
                state_nx = S_HI;
            end
            S_HI: if (block_valid && ready_d) begin
                take_hi  = 1'b1;
                state_nx = S_ISSUE;
            end
            S_ISSUE: if (core_ready) begin
                core_init = (blk_cnt == 32'd0);
                core_next = (blk_cnt != 32'd0);
                state_nx  = S_BUSY;
            end
            S_BUSY: if (core_digest_valid) state_nx = S_LO;
            default: state_nx = S_LO;
        endcase
    end

    // Any half that was not accepted above was unsolicited.
    assign overrun_set = block_valid && !(take_lo || take_hi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_LO;
            ready        <= 1'b0;
            ready_d      <= 1'b0;
            blk_cnt      <= 32'd0;
            core_block   <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nx;
            // Toggling on !ready keeps at most one half in flight.
            ready        <= ((state_nx == S_LO) || (state_nx == S_HI)) && !ready;
            ready_d      <= ready;
            digest_valid <= 1'b0;
            if (take_lo) core_block[1023:512] <= lo_mapped;
            if (take_hi) core_block[511:0]    <= hi_mapped;
            if (overrun_set) overrun <= 1'b1;
            if (state == S_BUSY && core_digest_valid) begin
                if (last_blk) begin
                    digest       <= core_digest;
                    digest_valid <= 1'b1;
                    blk_cnt      <= 32'd0;
                end else begin
                    blk_cnt <= blk_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha512_block_assembler.sv
// Self-checking bench for sha512_block_assembler: table-driven word-mapping
// vectors, directed multi-cycle sequences and randomized messages compared
// against a byte-level reference model.
module tb_sha512_block_assembler;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [511:0]  block = '0;
    logic          block_valid = 1'b0;
    logic          ready;
    logic [31:0]   msg_blocks = 32'd1;
    logic [1023:0] core_block;
    logic          core_init, core_next;
    logic          core_ready = 1'b0;
    logic [511:0]  core_digest = '0;
    logic          core_digest_valid = 1'b0;
    logic [511:0]  digest;
    logic          digest_valid;
    logic          overrun;

    sha512_block_assembler #(.BYTE_SWAP(1)) dut (
        .clk(clk), .reset(reset), .block(block), .block_valid(block_valid),
        .ready(ready), .msg_blocks(msg_blocks), .core_block(core_block),
        .core_init(core_init), .core_next(core_next), .core_ready(core_ready),
        .core_digest(core_digest), .core_digest_valid(core_digest_valid),
        .digest(digest), .digest_valid(digest_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: position inside current message and last digest.
    int             msg_pos = 0;
    int             exp_dv = 0;
    logic [511:0]   last_digest = '0;
    logic [1023:0]  cap_blk;

    // Protocol monitor
    int   n_dv = 0, bad_ready = 0, bad_start = 0;
    logic prev_ready = 1'b0, prev_start = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (ready && prev_ready) bad_ready <= bad_ready + 1;
            if (core_init && core_next) bad_start <= bad_start + 1;
            if ((core_init || core_next) && prev_start) bad_start <= bad_start + 1;
            if (digest_valid) n_dv <= n_dv + 1;
        end
        prev_ready <= ready;
        prev_start <= core_init || core_next;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            for (int w = 0; w < 16; w++)
                if (act[1023-64*w -: 64] !== exp[1023-64*w -: 64]) begin
                    $display("FAIL %s: word %0d got %h expected %h", nm, w,
                             act[1023-64*w -: 64], exp[1023-64*w -: 64]);
                    break;
                end
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: 128 host bytes (lower half first); SHA word w is built
    // big-endian from host bytes 8w..8w+7, byte 8w landing most significant.
    function automatic logic [1023:0] model_blk(input logic [511:0] lo, input logic [511:0] hi);
        logic [1023:0] r;
        logic [7:0]    src [128];
        for (int i = 0; i < 64; i++) begin
            src[i]      = lo[8*i +: 8];
            src[64 + i] = hi[8*i +: 8];
        end
        for (int w = 0; w < 16; w++)
            for (int j = 0; j < 8; j++)
                r[1023-64*w-8*j -: 8] = src[8*w + j];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for ready, then present the half in the following cycle.
    task automatic send_half(input logic [511:0] d);
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (!ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got no ready within 50 cycles");
        end
        tick();
        block       = d;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        block       = rnd512();
    endtask

    task automatic run_block(input logic [511:0] lo, input logic [511:0] hi, input int delay);
        logic [1023:0] exp_blk;
        logic [511:0]  dig;
        logic          first, last;
        int            eff, bad;
        eff   = (msg_blocks == 32'd0) ? 1 : int'(msg_blocks);
        first = (msg_pos == 0);
        last  = (msg_pos + 1 >= eff);
        send_half(lo);
        send_half(hi);
        exp_blk = model_blk(lo, hi);
        bad = 0;
        for (int i = 0; i < delay; i++) begin
            if (core_init || core_next || ready || core_block !== exp_blk) bad++;
            if (i == 0) begin
                // stray completion while waiting to issue: must be ignored
                core_digest       = rnd512();
                core_digest_valid = 1'b1;
            end
            tick();
            core_digest_valid = 1'b0;
        end
        if (delay > 0) chk1("issue_hold_quiet", bad == 0, 1'b1);
        core_ready = 1'b1;
        #1;
        chk1("core_init", core_init, first);
        chk1("core_next", core_next, !first);
        chk_blk("core_block", core_block, exp_blk);
        cap_blk = core_block;
        tick();
        core_ready = 1'b0;
        #1;
        chk1("start_single_cycle", core_init || core_next, 1'b0);
        bad = 0;
        repeat ($urandom_range(0, 3)) begin
            if (ready || core_block !== exp_blk) bad++;
            tick();
        end
        chk1("busy_stable_no_ready", bad == 0, 1'b1);
        dig               = rnd512();
        core_digest       = dig;
        core_digest_valid = 1'b1;
        tick();
        core_digest_valid = 1'b0;
        core_digest       = rnd512();
        chk1("digest_valid", digest_valid, last);
        if (last) begin
            last_digest = dig;
            msg_pos     = 0;
            exp_dv++;
        end else begin
            msg_pos++;
        end
        chk("digest", digest, last_digest);
        tick();
        chk1("digest_valid_one_cycle", digest_valid, 1'b0);
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        block_valid       = 1'b0;
        core_ready        = 1'b0;
        core_digest_valid = 1'b0;
        #1;
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_core_init", core_init, 1'b0);
        chk1("rst_core_next", core_next, 1'b0);
        chk1("rst_digest_valid", digest_valid, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk("rst_digest", digest, '0);
        chk_blk("rst_core_block", core_block, '0);
        msg_pos     = 0;
        last_digest = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        int          k;
        logic [63:0] win;
        logic [63:0] wexp;
    } map_vec_t;

    initial begin
        map_vec_t     tbl [6];
        logic [511:0] lo, hi;
        int           nblk;

        tbl[0] = '{0,  64'h0706050403020100, 64'h0001020304050607};
        tbl[1] = '{7,  64'h1122334455667788, 64'h8877665544332211};
        tbl[2] = '{8,  64'hDEADBEEF01234567, 64'h67452301EFBEADDE};
        tbl[3] = '{15, 64'h0123456789ABCDEF, 64'hEFCDAB8967452301};
        tbl[4] = '{3,  64'hFF00000000000000, 64'h00000000000000FF};
        tbl[5] = '{12, 64'h0000000000000080, 64'h8000000000000000};

        // Reset values and first ready pulse timing
        @(posedge clk);
        do_reset();
        chk1("ready_cycle1", ready, 1'b0);
        tick();
        chk1("ready_cycle2", ready, 1'b1);
        tick();
        chk1("ready_cycle3", ready, 1'b0);

        // Word-mapping table, one single-block message each
        msg_blocks = 32'd1;
        for (int i = 0; i < 6; i++) begin
            lo = rnd512();
            hi = rnd512();
            if (tbl[i].k < 8) lo[64*tbl[i].k +: 64] = tbl[i].win;
            else              hi[64*(tbl[i].k-8) +: 64] = tbl[i].win;
            run_block(lo, hi, i % 3);
            chk($sformatf("map_word%0d", tbl[i].k), 512'(cap_blk[1023-64*tbl[i].k -: 64]),
                512'(tbl[i].wexp));
        end

        // Three-block message: init, next, next, one digest
        msg_blocks = 32'd3;
        for (int b = 0; b < 3; b++) run_block(rnd512(), rnd512(), 0);

        // core_ready held low for 20 cycles in issue
        msg_blocks = 32'd2;
        run_block(rnd512(), rnd512(), 20);
        run_block(rnd512(), rnd512(), 1);

        // Randomized messages; msg_blocks changes only between messages
        for (int m = 0; m < 6; m++) begin
            msg_blocks = 32'($urandom_range(0, 4));
            nblk = (msg_blocks == 0) ? 1 : int'(msg_blocks);
            for (int b = 0; b < nblk; b++)
                run_block(rnd512(), rnd512(), $urandom_range(0, 3));
        end

        chk1("no_overrun_clean_run", overrun, 1'b0);

        // Unsolicited half: ignored, overrun sticky until reset
        do_reset();
        block       = rnd512();
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        chk1("overrun_set", overrun, 1'b1);
        msg_blocks = 32'd1;
        run_block(rnd512(), rnd512(), 0);
        chk1("overrun_sticky", overrun, 1'b1);

        // Reset after the lower half: partial data dropped, msg_blocks=0 as 1
        do_reset();
        msg_blocks = 32'd2;
        send_half(rnd512());
        do_reset();
        msg_blocks = 32'd0;
        run_block(rnd512(), rnd512(), 2);
        run_block(rnd512(), rnd512(), 0);

        tick();
        tick();
        chk("digest_valid_count", 512'(n_dv), 512'(exp_dv));
        chk("ready_back_to_back", 512'(bad_ready), '0);
        chk("start_overlap_or_repeat", 512'(bad_start), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
